// File: rtl/crack_pkg.sv
// crack_pkg: shared constants and types for the crack-engine coordinator.
//   KEY_W         - key width carried between host, coordinator and engines
//   MAX_ENG       - largest supported engine count
//   LANE_W        - width of a lane index (fits MAX_ENG lanes)
//   coord_state_t - coordinator FSM states
//   rounds_inc    - saturating increment for the sync-round counter
package crack_pkg;

    localparam int KEY_W   = 24;
    localparam int MAX_ENG = 8;
    localparam int LANE_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_SYNC,
        ST_FOUND,
        ST_EXHAUSTED
    } coord_state_t;

    function automatic logic [KEY_W-1:0] rounds_inc(input logic [KEY_W-1:0] r);
        return (&r) ? r : r + 1'b1;
    endfunction

endpackage

// File: rtl/crack_coord_lane_pick.sv
// lane_pick: combinational lowest-index priority encoder.
//   req - per-lane request vector
//   idx - index of the lowest-numbered set bit (0 when none set)
//   any - at least one request bit is set
module lane_pick
    import crack_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]      req,
    output logic [LANE_W-1:0] idx,
    output logic              any
);

    // Scan from the top down so the lowest set lane is the last to write.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = LANE_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crack_coord.sv
// crack_coord: coordinates NUM_ENG crack engines searching interleaved key
// spaces. Launches all engines together, broadcasts a sync once every live
// engine is parked in standby, and stops on the first reported key or when
// every engine has run out of keys.
//   clk, rst_n          - clock, asynchronous active-low reset
//   en / rdy            - host start request / coordinator idle or finished
//   key, key_valid      - winning key and its valid flag
//   found_lane          - index of the winning engine
//   rounds              - sync rounds issued since the last launch (saturating)
//   eng_en, eng_cancel  - per-engine one-cycle start / cancel pulses
//   eng_sync            - broadcast one-cycle sync pulse
//   eng_rdy, eng_standby, eng_key, eng_key_valid - per-engine status
//   eng_start_key, eng_key_increment             - constant key-space split
module crack_coord
    import crack_pkg::*;
#(
    parameter int NUM_ENG = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    output logic                     rdy,
    output logic [KEY_W-1:0]         key,
    output logic                     key_valid,
    output logic [LANE_W-1:0]        found_lane,
    output logic [KEY_W-1:0]         rounds,
    output logic [NUM_ENG-1:0]       eng_en,
    input  logic [NUM_ENG-1:0]       eng_rdy,
    output logic [NUM_ENG-1:0]       eng_cancel,
    output logic                     eng_sync,
    input  logic [NUM_ENG-1:0]       eng_standby,
    output logic [KEY_W*NUM_ENG-1:0] eng_start_key,
    output logic [KEY_W-1:0]         eng_key_increment,
    input  logic [KEY_W*NUM_ENG-1:0] eng_key,
    input  logic [NUM_ENG-1:0]       eng_key_valid
);

    coord_state_t       state;
    logic [NUM_ENG-1:0] done_q;
    logic [NUM_ENG-1:0] done_now;
    logic [NUM_ENG-1:0] cancel_mask;
    logic               sync_ign;
    logic               en_pending;
    logic               all_parked;
    logic               any_standby;
    logic [LANE_W-1:0]  win_idx;
    logic               win_any;
    logic [KEY_W-1:0]   win_key;

    // Lane i starts at key i and strides by NUM_ENG: the lanes interleave.
    for (genvar g = 0; g < NUM_ENG; g++) begin : g_start
        assign eng_start_key[g*KEY_W +: KEY_W] = KEY_W'(g);
    end
    assign eng_key_increment = KEY_W'(NUM_ENG);

    // An engine still shows rdy in the cycle its start pulse is out, so
    // done detection is masked while any eng_en is pending.
    assign en_pending  = |eng_en;
    assign done_now    = done_q | (eng_rdy & ~eng_key_valid & {NUM_ENG{~en_pending}});
    assign all_parked  = &(eng_standby | done_now);
    assign any_standby = |(eng_standby & ~done_now);
    // Winner and other key holders are never cancelled, nor are idle lanes.
    assign cancel_mask = ~done_now & ~eng_key_valid;

    lane_pick #(.N(NUM_ENG)) u_pick (
        .req (eng_key_valid),
        .idx (win_idx),
        .any (win_any)
    );

    always_comb begin
        win_key = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (LANE_W'(i) == win_idx) win_key = eng_key[i*KEY_W +: KEY_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rdy        <= 1'b1;
            key        <= '0;
            key_valid  <= 1'b0;
            found_lane <= '0;
            rounds     <= '0;
            eng_en     <= '0;
            eng_cancel <= '0;
            eng_sync   <= 1'b0;
            done_q     <= '0;
            sync_ign   <= 1'b0;
        end else begin
            eng_en     <= '0;
            eng_cancel <= '0;
            eng_sync   <= 1'b0;
            case (state)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                    if (en) begin
                        state      <= ST_LAUNCH;
                        rdy        <= 1'b0;
                        key        <= '0;
                        key_valid  <= 1'b0;
                        found_lane <= '0;
                        rounds     <= '0;
                        done_q     <= '0;
                        sync_ign   <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    if (&eng_rdy) begin
                        eng_en <= '1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    done_q   <= done_now;
                    sync_ign <= 1'b0;
                    if (win_any) begin
                        state      <= ST_FOUND;
                        rdy        <= 1'b1;
                        key_valid  <= 1'b1;
                        key        <= win_key;
                        found_lane <= win_idx;
                        eng_cancel <= cancel_mask;
                    end else if (&done_now) begin
                        state <= ST_EXHAUSTED;
                        rdy   <= 1'b1;
                    end else if (!sync_ign && all_parked && any_standby) begin
                        state    <= ST_SYNC;
                        eng_sync <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    // Standby seen in the next RUN cycle predates this sync.
                    rounds   <= rounds_inc(rounds);
                    sync_ign <= 1'b1;
                    state    <= ST_RUN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
